deint_sched: RTL

- Symbol scheduler for the receive-side 802.11a block deinterleaver.
- Accepts the serial demapped coded-bit stream and splits it into NCBPS-bit symbols.
- Drives a two-bank (ping-pong) symbol store in the deinterleaver core: one bank is written while the other is read out in permuted order, so the stream never stalls for a full symbol.
- Validates frame length, counts symbols, flags the last symbol and signals frame completion.

---
 rtl/deint_sched.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/deint_sched.sv
// rtl/deint_sched.sv - symbol scheduler for the 802.11a receive block deinterleaver
// Splits the coded-bit stream into NCBPS-bit symbols and drives a ping-pong bank store.
module deint_sched #(
    parameter int NCBPS  = 48,
    parameter int ADDR_W = 6,
    parameter int SYM_W  = 7
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [11:0]       size_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              wr_en_o,
    output logic              wr_bank_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              rd_en_o,
    output logic              rd_bank_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              out_valid_o,
    output logic              last_sym_o,
    output logic [SYM_W-1:0]  sym_count_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_DRAIN} state_t;

    localparam logic [11:0]       NCBPS_W   = 12'(NCBPS);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NCBPS - 1);

    state_t             state_q, state_d;
    logic [11:0]        rem_q, rem_d;
    logic [SYM_W-1:0]   nsym_q, nsym_d;
    logic [SYM_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [SYM_W-1:0]   sym_count_q, sym_count_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic               rd_en_q, rd_en_d;
    logic [1:0]         full_q, full_d;
    logic               out_valid_q, out_valid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               in_ready;
    logic               wr_en;

    assign in_ready = (state_q == S_RUN) && !full_q[wr_bank_q] && (wr_cnt_q < nsym_q);
    assign wr_en    = in_valid_i && in_ready;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        nsym_d      = nsym_q;
        wr_cnt_d    = wr_cnt_q;
        sym_count_d = sym_count_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        rd_en_d     = rd_en_q;
        full_d      = full_q;
        out_valid_d = rd_en_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    rem_d       = size_i;
                    nsym_d      = '0;
                    sym_count_d = '0;
                    wr_cnt_d    = '0;
                    wr_addr_d   = '0;
                    rd_addr_d   = '0;
                    wr_bank_d   = 1'b0;
                    rd_bank_d   = 1'b0;
                    full_d      = 2'b00;
                    state_d     = S_CHECK;
                end
            end
            // Repeated subtraction: one symbol per cycle, remainder must end at zero.
            S_CHECK: begin
                if (rem_q >= NCBPS_W) begin
                    rem_d  = rem_q - NCBPS_W;
                    nsym_d = nsym_q + SYM_W'(1);
                end else if (rem_q == 12'd0 && nsym_q != '0) begin
                    state_d = S_RUN;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (wr_en) begin
                    if (wr_addr_q == ADDR_LAST) begin
                        wr_addr_d         = '0;
                        wr_bank_d         = ~wr_bank_q;
                        full_d[wr_bank_q] = 1'b1;
                        wr_cnt_d          = wr_cnt_q + SYM_W'(1);
                        if (wr_cnt_d == nsym_q) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (out_valid_q && !rd_en_q && sym_count_q == nsym_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Read side sees a fill landing on this edge so readout starts the very next cycle.
        if (state_q == S_RUN || state_q == S_DRAIN) begin
            if (rd_en_q) begin
                if (rd_addr_q == ADDR_LAST) begin
                    rd_addr_d         = '0;
                    rd_en_d           = 1'b0;
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    sym_count_d       = sym_count_q + SYM_W'(1);
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
            end else if (full_d[rd_bank_q]) begin
                rd_en_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            nsym_q      <= '0;
            wr_cnt_q    <= '0;
            sym_count_q <= '0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_en_q     <= 1'b0;
            full_q      <= 2'b00;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            nsym_q      <= nsym_d;
            wr_cnt_q    <= wr_cnt_d;
            sym_count_q <= sym_count_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            rd_en_q     <= rd_en_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready_o  = in_ready;
    assign wr_en_o     = wr_en;
    assign wr_bank_o   = wr_bank_q;
    assign wr_addr_o   = wr_addr_q;
    assign rd_en_o     = rd_en_q;
    assign rd_bank_o   = rd_bank_q;
    assign rd_addr_o   = rd_addr_q;
    assign out_valid_o = out_valid_q;
    assign last_sym_o  = rd_en_q && (sym_count_q == nsym_q - SYM_W'(1));
    assign sym_count_o = sym_count_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule
